// File: rtl/gps_frontend_sampler_if.sv
// Bundle between the RF front end / correlator and gps_frontend_sampler.
// The test_mode wire exists only when GPS_FE_TESTGEN_EN is defined.
interface gps_frontend_sampler_if;
    logic        fe_clk;
    logic        fe_sign;
    logic        fe_mag;
    logic        enable;
    logic [15:0] mag_window;
`ifdef GPS_FE_TESTGEN_EN
    logic        test_mode;
`endif
    // sample_valid / mag_count_valid are single-cycle pulses with no back-pressure:
    // the consumer must take sign/mag (or mag_count) in the cycle the pulse is high.
    logic        sign;
    logic        mag;
    logic        sample_valid;
    logic [15:0] mag_count;
    logic        mag_count_valid;

    modport master (
        output fe_clk, fe_sign, fe_mag, enable, mag_window,
`ifdef GPS_FE_TESTGEN_EN
        output test_mode,
`endif
        input  sign, mag, sample_valid, mag_count, mag_count_valid
    );

    modport slave (
        input  fe_clk, fe_sign, fe_mag, enable, mag_window,
`ifdef GPS_FE_TESTGEN_EN
        input  test_mode,
`endif
        output sign, mag, sample_valid, mag_count, mag_count_valid
    );
endinterface

// File: rtl/gps_frontend_sampler.sv
// Brings a sign/magnitude RF front end into the correlator clock domain and counts mag=1
// samples per window. Optional internal LFSR test source compiled in by GPS_FE_TESTGEN_EN.
module gps_frontend_sampler (
    input logic                   correlator_clk,
    input logic                   correlator_rst,
    gps_frontend_sampler_if.slave fe
);
    logic        fe_clk_s1_q, fe_clk_s2_q, fe_clk_s3_q;
    logic        sign_s1_q, sign_s2_q, mag_s1_q, mag_s2_q;
    logic        sign_q, sign_d, mag_q, mag_d, sv_q, sv_d, mcv_q, mcv_d;
    logic        en_q;
    logic [15:0] len_q, len_d, smp_cnt_q, smp_cnt_d, mag_cnt_q, mag_cnt_d;
    logic [15:0] mag_count_q, mag_count_d;
    logic        smp_edge, new_sign, new_mag, fire, en_rise, wrap;
    logic [15:0] len_eff, cnt_inc, mag_inc;

`ifdef GPS_FE_TESTGEN_EN
    logic [1:0]  div_q, div_d;
    logic [9:0]  lfsr_q, lfsr_d, lfsr_next;
`endif

    always_ff @(posedge correlator_clk) begin
        if (correlator_rst) begin
            fe_clk_s1_q <= 1'b0; fe_clk_s2_q <= 1'b0; fe_clk_s3_q <= 1'b0;
            sign_s1_q   <= 1'b0; sign_s2_q   <= 1'b0;
            mag_s1_q    <= 1'b0; mag_s2_q    <= 1'b0;
            sign_q      <= 1'b0; mag_q       <= 1'b0;
            sv_q        <= 1'b0; mcv_q       <= 1'b0;
            en_q        <= 1'b0;
            len_q       <= 16'd0; smp_cnt_q  <= 16'd0;
            mag_cnt_q   <= 16'd0; mag_count_q <= 16'd0;
        end else begin
            fe_clk_s1_q <= fe.fe_clk; fe_clk_s2_q <= fe_clk_s1_q; fe_clk_s3_q <= fe_clk_s2_q;
            sign_s1_q   <= fe.fe_sign; sign_s2_q  <= sign_s1_q;
            mag_s1_q    <= fe.fe_mag;  mag_s2_q   <= mag_s1_q;
            sign_q      <= sign_d;  mag_q      <= mag_d;
            sv_q        <= sv_d;    mcv_q      <= mcv_d;
            en_q        <= fe.enable;
            len_q       <= len_d;   smp_cnt_q  <= smp_cnt_d;
            mag_cnt_q   <= mag_cnt_d; mag_count_q <= mag_count_d;
        end
    end

`ifdef GPS_FE_TESTGEN_EN
    always_ff @(posedge correlator_clk) begin
        if (correlator_rst) begin
            div_q  <= 2'd0;
            lfsr_q <= 10'h3FF;
        end else begin
            div_q  <= div_d;
            lfsr_q <= lfsr_d;
        end
    end
`endif

    // Sample source: the synchronised fe_clk rising edge, or the internal test source.
    always_comb begin
        smp_edge = fe_clk_s2_q & ~fe_clk_s3_q;
        new_sign = sign_s2_q;
        new_mag  = mag_s2_q;
`ifdef GPS_FE_TESTGEN_EN
        lfsr_next = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[2]};
        div_d     = 2'd0;
        lfsr_d    = lfsr_q;
        if (fe.test_mode) begin
            div_d    = div_q + 2'd1;
            smp_edge = (div_q == 2'd3);
            new_sign = lfsr_next[0];
            new_mag  = lfsr_next[1];
            if (smp_edge) lfsr_d = lfsr_next;
        end
`endif
    end

    // A latched length of 0 or an enable rise means a new window starts now, so the
    // live mag_window value governs this cycle's comparison.
    always_comb begin
        fire        = smp_edge & fe.enable;
        en_rise     = fe.enable & ~en_q;
        len_eff     = ((len_q == 16'd0) || en_rise) ? fe.mag_window : len_q;
        cnt_inc     = smp_cnt_q + 16'd1;
        mag_inc     = mag_cnt_q + {15'd0, new_mag};
        wrap        = fire && (len_eff != 16'd0) && (cnt_inc == len_eff);

        sign_d      = fire ? new_sign : sign_q;
        mag_d       = fire ? new_mag  : mag_q;
        sv_d        = fire;
        mcv_d       = 1'b0;
        len_d       = len_eff;
        smp_cnt_d   = smp_cnt_q;
        mag_cnt_d   = mag_cnt_q;
        mag_count_d = mag_count_q;

        if (!fe.enable || (len_eff == 16'd0)) begin
            smp_cnt_d = 16'd0;
            mag_cnt_d = 16'd0;
        end else if (wrap) begin
            smp_cnt_d   = 16'd0;
            mag_cnt_d   = 16'd0;
            mag_count_d = mag_inc;
            mcv_d       = 1'b1;
            len_d       = fe.mag_window;
        end else if (fire) begin
            smp_cnt_d = cnt_inc;
            mag_cnt_d = mag_inc;
        end
    end

    assign fe.sign            = sign_q;
    assign fe.mag             = mag_q;
    assign fe.sample_valid    = sv_q;
    assign fe.mag_count       = mag_count_q;
    assign fe.mag_count_valid = mcv_q;
endmodule

// File: tb/tb_gps_frontend_sampler.sv
// Self-checking bench for gps_frontend_sampler: vector table plus directed sequences,
// with a scoreboard queue matched against every sample_valid pulse.
module tb_gps_frontend_sampler;
    logic clk;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_fail;

    gps_frontend_sampler_if bus ();

    gps_frontend_sampler dut (
        .correlator_clk (clk),
        .correlator_rst (rst),
        .fe             (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // expected word: {cycle[31:0], sign, mag, mag_count_valid, mag_count[15:0]}
    logic [50:0] exp_q[$];
    logic [1:0]  last_sm;
    logic [15:0] last_cnt;
    logic        tg_mode;
    logic [9:0]  tg_lfsr;
    int          tg_prev;
    int          tg_n;

    typedef struct {
        logic [15:0] win;
        logic        m;
        logic        mcv;
        logic [15:0] cnt;
    } vec_t;
    vec_t vecs[$];

    // scoreboard / monitor
    always @(posedge clk) begin
        logic [50:0] w;
        logic [50:0] got;
        #1;
        if (rst) begin
            n_chk++;
            if ({bus.sign, bus.mag, bus.sample_valid, bus.mag_count_valid, bus.mag_count} !== 20'd0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d: got s=%0b m=%0b sv=%0b mcv=%0b cnt=%0d, required all 0",
                         cyc, bus.sign, bus.mag, bus.sample_valid, bus.mag_count_valid, bus.mag_count);
            end
            last_sm  = 2'b00;
            last_cnt = 16'd0;
            tg_lfsr  = 10'h3FF;
            tg_prev  = -1;
        end else if (bus.sample_valid && tg_mode) begin
            tg_lfsr = {tg_lfsr[8:0], tg_lfsr[9] ^ tg_lfsr[2]};
            tg_n++;
            n_chk++;
            if ({bus.sign, bus.mag, bus.mag_count_valid} !== {tg_lfsr[0], tg_lfsr[1], 1'b0}) begin
                n_fail++;
                $display("FAIL tg_sample cyc=%0d: got s=%0b m=%0b mcv=%0b, required s=%0b m=%0b mcv=0",
                         cyc, bus.sign, bus.mag, bus.mag_count_valid, tg_lfsr[0], tg_lfsr[1]);
            end
            if (tg_prev >= 0) begin
                n_chk++;
                if (cyc - tg_prev != 4) begin
                    n_fail++;
                    $display("FAIL tg_spacing: got %0d cycles, required 4", cyc - tg_prev);
                end
            end
            tg_prev = cyc;
            last_sm = {tg_lfsr[0], tg_lfsr[1]};
        end else if (bus.sample_valid) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_sample cyc=%0d: got sample_valid=1, required 0", cyc);
            end else begin
                w   = exp_q.pop_front();
                got = {cyc[31:0], bus.sign, bus.mag, bus.mag_count_valid, bus.mag_count};
                if (got !== w) begin
                    n_fail++;
                    $display("FAIL sample: got cyc=%0d s=%0b m=%0b mcv=%0b cnt=%0d, required cyc=%0d s=%0b m=%0b mcv=%0b cnt=%0d",
                             got[50:19], got[18], got[17], got[16], got[15:0],
                             w[50:19], w[18], w[17], w[16], w[15:0]);
                end
                last_sm  = w[18:17];
                last_cnt = w[15:0];
            end
        end else begin
            n_chk++;
            if ({bus.sign, bus.mag, bus.mag_count_valid, bus.mag_count} !== {last_sm, 1'b0, last_cnt}) begin
                n_fail++;
                $display("FAIL hold cyc=%0d: got s=%0b m=%0b mcv=%0b cnt=%0d, required s=%0b m=%0b mcv=0 cnt=%0d",
                         cyc, bus.sign, bus.mag, bus.mag_count_valid, bus.mag_count,
                         last_sm[1], last_sm[0], last_cnt);
            end
        end
    end

    // driver tasks
    task automatic send(input logic s, input logic m, input logic mcv, input logic [15:0] cnt,
                        input logic push);
        @(negedge clk);
        bus.fe_sign = s;
        bus.fe_mag  = m;
        @(negedge clk);
        bus.fe_clk = 1'b1;
        if (push) exp_q.push_back({cyc[31:0] + 32'd3, s, m, mcv, cnt});
        repeat (4) @(negedge clk);
        bus.fe_clk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic sendr(input logic m, input logic mcv, input logic [15:0] cnt);
        send(1'($urandom_range(0, 1)), m, mcv, cnt, 1'b1);
    endtask

    task automatic add(input logic [15:0] w, input logic m, input logic mcv, input logic [15:0] c);
        vec_t v;
        v.win = w; v.m = m; v.mcv = mcv; v.cnt = c;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        cyc = 0; n_chk = 0; n_fail = 0;
        tg_mode = 1'b0; tg_n = 0; tg_prev = -1; tg_lfsr = 10'h3FF;
        last_sm = 2'b00; last_cnt = 16'd0;
        rst = 1'b1;
        bus.fe_clk = 1'b0; bus.fe_sign = 1'b0; bus.fe_mag = 1'b0;
        bus.enable = 1'b1; bus.mag_window = 16'd0;
`ifdef GPS_FE_TESTGEN_EN
        bus.test_mode = 1'b0;
`endif

        // window 4, pattern 1,0,1,1 twice
        add(4, 1, 0, 0); add(4, 0, 0, 0); add(4, 1, 0, 0); add(4, 1, 1, 3);
        add(4, 1, 0, 3); add(4, 0, 0, 3); add(4, 1, 0, 3); add(4, 1, 1, 3);
        // window shrinks 4->2 after two samples: current window still ends at 4
        add(4, 1, 0, 3); add(4, 1, 0, 3); add(2, 0, 0, 3); add(2, 1, 1, 3);
        add(2, 1, 0, 3); add(2, 1, 1, 2); add(2, 0, 0, 2); add(2, 1, 1, 1);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // statistics off, constant sign=1 mag=0, one rise every 8 cycles
        repeat (4) send(1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
        drain("drain_basic");

        foreach (vecs[i]) begin
            bus.mag_window = vecs[i].win;
            sendr(vecs[i].m, vecs[i].mcv, vecs[i].cnt);
        end
        drain("drain_table");

        // enable dropped mid-window for 20 cycles, re-enabled with window 3
        sendr(1'b1, 1'b0, 16'd1);
        bus.enable = 1'b0;
        send(1'b1, 1'b1, 1'b0, 16'd0, 1'b0);
        send(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
        bus.mag_window = 16'd3;
        repeat (4) @(negedge clk);
        check("disabled_mag_count", 32'(bus.mag_count), 32'd1);
        bus.enable = 1'b1;
        sendr(1'b1, 1'b0, 16'd1);
        sendr(1'b0, 1'b0, 16'd1);
        sendr(1'b1, 1'b1, 16'd2);
        sendr(1'b0, 1'b0, 16'd2);
        sendr(1'b0, 1'b0, 16'd2);
        sendr(1'b0, 1'b1, 16'd0);
        drain("drain_enable");

        // one-cycle reset mid-window discards the partial window
        sendr(1'b1, 1'b0, 16'd0);
        sendr(1'b1, 1'b0, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mag_count", 32'(bus.mag_count), 32'd0);
        check("rst_sign_mag", 32'({bus.sign, bus.mag}), 32'd0);
        rst = 1'b0;
        sendr(1'b1, 1'b0, 16'd0);
        sendr(1'b0, 1'b0, 16'd0);
        bus.mag_window = 16'd1;
        sendr(1'b0, 1'b1, 16'd1);
        drain("drain_reset");

        // window length 1, then switched to 0
        sendr(1'b1, 1'b1, 16'd1);
        sendr(1'b0, 1'b1, 16'd0);
        bus.mag_window = 16'd0;
        sendr(1'b1, 1'b1, 16'd1);
        sendr(1'b1, 1'b0, 16'd1);
        sendr(1'b0, 1'b0, 16'd1);
        drain("drain_len01");

`ifdef GPS_FE_TESTGEN_EN
        @(negedge clk);
        rst = 1'b1;
        bus.test_mode = 1'b1;
        bus.mag_window = 16'd0;
        bus.enable = 1'b1;
        tg_mode = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (48) @(negedge clk);
        check("tg_sample_count", 32'(tg_n >= 10), 32'd1);
        rst = 1'b1;
        bus.test_mode = 1'b0;
        @(negedge clk);
        tg_mode = 1'b0;
        rst = 1'b0;
        repeat (4) @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/gps_frontend_sampler.md
GPS_FRONTEND_SAMPLER -- requirements
Module: gps_frontend_sampler

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 SHALL provide these ports:
- correlator_clk  in  1  system clock; all logic on its rising edge
- correlator_rst  in  1  synchronous, active-high reset
- fe_clk  in  1  RF front-end sample clock, asynchronous; period at least 4 correlator_clk periods
- fe_sign  in  1  raw front-end sign bit, asynchronous, stable around fe_clk rising edge
- fe_mag  in  1  raw front-end magnitude bit, same timing as fe_sign
- enable  in  1  sampler enable
- mag_window  in  16  samples per magnitude-statistics window; 0 = statistics off
- test_mode  in  1  selects internal test source; present only with GPS_FE_TESTGEN_EN
- sign  out  1  registered sample sign, feeds correlator sign
- mag  out  1  registered sample magnitude, feeds correlator mag
- sample_valid  out  1  one-cycle pulse when sign/mag update
- mag_count  out  16  count of mag=1 samples in the last completed window
- mag_count_valid  out  1  one-cycle pulse when mag_count updates

Function
REQ-003 SHALL synchronise fe_clk, fe_sign and fe_mag each through two flops (s1, s2), plus a third flop s3 on the fe_clk path.
REQ-004 SHALL detect a sample edge when fe_clk s2=1 and s3=0.
REQ-005 On a sample edge with enable=1, SHALL load sign/mag from the fe_sign/fe_mag s2 stage and assert sample_valid in the same cycle as the new sign/mag value.
REQ-006 Latency: sample_valid SHALL assert exactly 3 correlator_clk edges after the first edge that samples fe_clk high.
REQ-007 sign/mag SHALL hold between sample edges.
REQ-008 sample_valid SHALL never be high for two consecutive cycles.
REQ-009 With enable=0:
- sample_valid SHALL stay 0.
- sign/mag SHALL hold.
- window counters SHALL clear.
- mag_count SHALL hold.
REQ-010 The window length SHALL be latched from mag_window at window start (after reset, after a window completes, on enable rising, and when leaving the mag_window=0 state).
- A mid-window change takes effect only in the next window.
REQ-011 Window behaviour:
- Each sample_valid SHALL increment a 16-bit sample counter.
- It SHALL also increment a 16-bit mag counter when the new mag=1.
- When the sample counter reaches the latched length, in the same cycle the block SHALL load mag_count with the final mag total (including the current sample), pulse mag_count_valid, and clear both counters.
REQ-012 With latched length 0:
- counters SHALL stay 0.
- mag_count_valid SHALL never assert.
REQ-013 Latched length 1 SHALL produce mag_count_valid on every sample_valid, with mag_count equal to that sample's mag.
REQ-014 mag_count SHALL never exceed the latched length; no saturation logic is required.

Reset
REQ-015 While correlator_rst=1, all synchroniser flops, sign, mag, sample_valid, mag_count, mag_count_valid, counters and the latched window length SHALL be 0, and the test LFSR SHALL be 10'h3FF.
REQ-016 Reset asserted mid-window SHALL discard the partial window; no mag_count_valid SHALL be emitted for it.
REQ-017 The first sample edge SHALL be detected no earlier than the fourth cycle after reset deassertion, so no spurious edge occurs from the reset state.

Configuration
REQ-018 The macro GPS_FE_TESTGEN_EN SHALL compile in an internal test source.
REQ-019 With GPS_FE_TESTGEN_EN defined and test_mode=1:
- A 2-bit divider SHALL generate an internal sample edge every 4th cycle, replacing the fe_clk edge detect.
- A 10-bit Fibonacci LFSR (x^10+x^3+1, seed 10'h3FF) SHALL advance on each internal edge.
- sign SHALL be LFSR bit 0 and mag SHALL be LFSR bit 1, taken after the advance.
- The synchroniser outputs SHALL be ignored.
REQ-020 With GPS_FE_TESTGEN_EN defined and test_mode=0, behaviour SHALL be identical to the macro-undefined build.
REQ-021 Without GPS_FE_TESTGEN_EN, the test_mode port, LFSR and divider SHALL be absent.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset release, then fe_clk toggling every 8 cycles with fe_sign=1, fe_mag=0 -> sample_valid every 8 cycles, 3 cycles after each fe_clk rise; sign=1, mag=0.
- mag_window=4, fe_mag pattern 1,0,1,1 repeated -> mag_count_valid on every 4th sample_valid with mag_count=3.
- mag_window changed 4->2 after 2 samples of a window -> that window completes at 4 samples; following windows complete every 2.
- enable dropped for 20 cycles mid-window, then raised with mag_window=3 -> no sample_valid while low; first mag_count_valid on the 3rd sample after re-enable; mag_count holds its old value meanwhile.
- correlator_rst pulsed for 1 cycle mid-window -> all outputs 0 next cycle; no mag_count_valid for the interrupted window.
- GPS_FE_TESTGEN_EN build, test_mode=1, mag_window=0 -> sample_valid every 4 cycles; sign/mag sequence matches a reference x^10+x^3+1 LFSR model seeded 3FF; mag_count_valid never asserts.
